// File: rtl/pc_redirect_unit.sv
// Fetch-stage PC generator: selects reset, trap, trap-return, EX redirect or
// sequential PC, buffering redirects that arrive while fetch is stalled.
module pc_redirect_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              INSTR_BYTES  = 4,
    parameter int              CAUSE_W      = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               StallF,
    input  logic               PCSrcE,
    input  logic [XLEN-1:0]    PCTargetE,
    input  logic               returnM,
    input  logic [XLEN-1:0]    returnadress,
    input  logic               trapM,
    input  logic               trap_is_int,
    input  logic [CAUSE_W-1:0] trap_cause,
    input  logic [XLEN-1:0]    mtvec,
    output logic [XLEN-1:0]    PCF,
    output logic [XLEN-1:0]    PCPlusF,
    output logic               redirect_pend,
    output logic               pc_misalignF
);

    typedef enum logic {
        RUN,
        HOLD
    } state_t;

    // Request priority levels; larger wins, NONE means sequential.
    localparam logic [1:0] LVL_NONE = 2'd0;
    localparam logic [1:0] LVL_BR   = 2'd1;
    localparam logic [1:0] LVL_RET  = 2'd2;
    localparam logic [1:0] LVL_TRAP = 2'd3;

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);
    localparam logic [XLEN-1:0] INC        = XLEN'(INSTR_BYTES);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] buf_tgt_q, buf_tgt_d;
    logic [1:0]      buf_lvl_q, buf_lvl_d;
    logic            mis_q;

    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] trap_off;
    logic [XLEN-1:0] trap_tgt;
    logic [XLEN-1:0] new_tgt;
    logic [1:0]      new_lvl;
    logic            new_wins;

    assign trap_base = {mtvec[XLEN-1:2], 2'b00};
    assign trap_off  = (mtvec[1:0] == 2'b01 && trap_is_int)
                     ? (XLEN'(trap_cause) << 2) : '0;
    assign trap_tgt  = trap_base + trap_off;

    always_comb begin
        new_lvl = LVL_NONE;
        new_tgt = '0;
        if (trapM) begin
            new_lvl = LVL_TRAP;
            new_tgt = trap_tgt;
        end else if (returnM) begin
            new_lvl = LVL_RET;
            new_tgt = returnadress;
        end else if (PCSrcE) begin
            new_lvl = LVL_BR;
            new_tgt = PCTargetE;
        end
    end

    // Equal priority counts as a win so the newest target is kept.
    assign new_wins = (new_lvl != LVL_NONE) && (new_lvl >= buf_lvl_q);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        buf_tgt_d = buf_tgt_q;
        buf_lvl_d = buf_lvl_q;
        unique case (state_q)
            RUN: begin
                if (!StallF) begin
                    pc_d = (new_lvl != LVL_NONE) ? new_tgt : PCPlusF;
                end else if (new_lvl != LVL_NONE) begin
                    buf_tgt_d = new_tgt;
                    buf_lvl_d = new_lvl;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (StallF) begin
                    if (new_wins) begin
                        buf_tgt_d = new_tgt;
                        buf_lvl_d = new_lvl;
                    end
                end else begin
                    pc_d      = new_wins ? new_tgt : buf_tgt_q;
                    buf_lvl_d = LVL_NONE;
                    state_d   = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            pc_q      <= RESET_VECTOR;
            mis_q     <= (RESET_VECTOR & ALIGN_MASK) != '0;
            buf_tgt_q <= '0;
            buf_lvl_q <= LVL_NONE;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            mis_q     <= (pc_d & ALIGN_MASK) != '0;
            buf_tgt_q <= buf_tgt_d;
            buf_lvl_q <= buf_lvl_d;
        end
    end

    assign PCF           = pc_q;
    assign PCPlusF       = pc_q + INC;
    assign redirect_pend = (state_q == HOLD);
    assign pc_misalignF  = mis_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed-vector bench for pc_redirect_unit with RESET_VECTOR=0x100.
module tb_pc_redirect_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        StallF;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        returnM;
    logic [31:0] returnadress;
    logic        trapM;
    logic        trap_is_int;
    logic [4:0]  trap_cause;
    logic [31:0] mtvec;
    logic [31:0] PCF;
    logic [31:0] PCPlusF;
    logic        redirect_pend;
    logic        pc_misalignF;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_redirect_unit #(
        .XLEN(32),
        .RESET_VECTOR(32'h100),
        .INSTR_BYTES(4),
        .CAUSE_W(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .StallF(StallF),
        .PCSrcE(PCSrcE),
        .PCTargetE(PCTargetE),
        .returnM(returnM),
        .returnadress(returnadress),
        .trapM(trapM),
        .trap_is_int(trap_is_int),
        .trap_cause(trap_cause),
        .mtvec(mtvec),
        .PCF(PCF),
        .PCPlusF(PCPlusF),
        .redirect_pend(redirect_pend),
        .pc_misalignF(pc_misalignF)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        PCSrcE  = 1'b0;
        returnM = 1'b0;
        trapM   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; StallF = 1'b0; idle();
        PCTargetE = '0; returnadress = '0;
        trap_is_int = 1'b0; trap_cause = '0; mtvec = '0;
        step();
        check("rst_pc", PCF, 32'h100);
        check("rst_pend", 32'(redirect_pend), 0);
        check("rst_mis", 32'(pc_misalignF), 0);
        check("rst_plus", PCPlusF, 32'h104);
        rst = 1'b0;
        step(); check("seq1", PCF, 32'h104);
        step(); check("seq2", PCF, 32'h108);

        PCSrcE = 1'b1; PCTargetE = 32'h200;
        step(); check("br200", PCF, 32'h200);

        StallF = 1'b1; PCTargetE = 32'h400;
        step(); check("stl1_pc", PCF, 32'h200);
        check("stl1_pend", 32'(redirect_pend), 1);
        idle();
        step(); check("stl2_pc", PCF, 32'h200);
        step(); check("stl3_pc", PCF, 32'h200);
        check("stl3_pend", 32'(redirect_pend), 1);
        StallF = 1'b0;
        step(); check("rel_pc", PCF, 32'h400);
        check("rel_pend", 32'(redirect_pend), 0);

        StallF = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h500;
        step(); idle();
        trapM = 1'b1; mtvec = 32'h801; trap_is_int = 1'b1; trap_cause = 5'd7;
        step(); check("trapbuf_pc", PCF, 32'h400);
        idle(); StallF = 1'b0;
        step(); check("vec_int", PCF, 32'h81C);

        trapM = 1'b1; returnM = 1'b1; returnadress = 32'h300;
        trap_is_int = 1'b0;
        step(); check("trap_vs_ret", PCF, 32'h800);
        check("trap_mis", 32'(pc_misalignF), 0);
        idle();

        StallF = 1'b1; returnM = 1'b1; returnadress = 32'h300;
        step(); check("retbuf_pend", 32'(redirect_pend), 1);
        idle(); PCSrcE = 1'b1; PCTargetE = 32'h600;
        step(); check("lowig_pc", PCF, 32'h800);
        idle(); StallF = 1'b0;
        step(); check("ret_rel", PCF, 32'h300);

        StallF = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h700;
        step(); idle();
        StallF = 1'b0; returnM = 1'b1; returnadress = 32'h900;
        step(); check("rel_newwin", PCF, 32'h900);
        check("rel_newwin_p", 32'(redirect_pend), 0);
        idle();

        trapM = 1'b1; trap_is_int = 1'b1; mtvec = 32'h803;
        step(); check("mode3_direct", PCF, 32'h800);
        idle();

        PCSrcE = 1'b1; PCTargetE = 32'h402;
        step(); check("mis_pc", PCF, 32'h402);
        check("mis_flag", 32'(pc_misalignF), 1);
        check("mis_plus", PCPlusF, 32'h406);

        StallF = 1'b1; PCTargetE = 32'h404;
        step(); check("hold_pend", 32'(redirect_pend), 1);
        idle(); rst = 1'b1;
        step(); check("rsth_pc", PCF, 32'h100);
        check("rsth_pend", 32'(redirect_pend), 0);
        check("rsth_mis", 32'(pc_misalignF), 0);
        rst = 1'b0; StallF = 1'b0;
        step(); check("rsth_seq", PCF, 32'h104);

        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFF;
        step(); check("wrap_plus", PCPlusF, 32'h3);
        check("wrap_mis", 32'(pc_misalignF), 1);
        idle();
        step(); check("wrap_pc", PCF, 32'h3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
